// File: rtl/psum_accumulator_if.sv
// Product-in / psum-out handshake bundle for the partial-sum accumulator.
// The accumulator takes the slave side; the upstream PE and the psum sink take the master side.
interface psum_accumulator_if #(
   parameter int DATA_WIDTH_PROD = 16,
   parameter int DATA_WIDTH_SUM  = 20,
   parameter int PSUM_DEPTH      = 4
);
   localparam int IDX_W = (PSUM_DEPTH > 1) ? $clog2(PSUM_DEPTH) : 1;

   logic                              prod_valid_i;
   logic                              prod_ready_o;
   logic signed [DATA_WIDTH_PROD-1:0] prod_i;
   logic                              psum_valid_o;
   logic                              psum_ready_i;
   logic signed [DATA_WIDTH_SUM-1:0]  psum_o;
   logic        [IDX_W-1:0]           psum_idx_o;

   modport master (
      output prod_valid_i, prod_i, psum_ready_i,
      input  prod_ready_o, psum_valid_o, psum_o, psum_idx_o
   );

   modport slave (
      input  prod_valid_i, prod_i, psum_ready_i,
      output prod_ready_o, psum_valid_o, psum_o, psum_idx_o
   );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates signed products round-robin into PSUM_DEPTH psum entries; after ACC_LEN
// full passes the finished psums are drained one per handshake, then accumulation resumes.
module psum_accumulator #(
   parameter int DATA_WIDTH_PROD = 16,
   parameter int DATA_WIDTH_SUM  = 20,
   parameter int PSUM_DEPTH      = 4,
   parameter int ACC_LEN         = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clear_i,
   output logic               busy_o,
   psum_accumulator_if.slave  bus
);
   localparam int IDX_W  = (PSUM_DEPTH > 1) ? $clog2(PSUM_DEPTH) : 1;
   localparam int PASS_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PSUM_DEPTH - 1);
   localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(ACC_LEN - 1);

   typedef enum logic {
      ST_ACCUM,
      ST_DRAIN
   } state_e;

   state_e                           state;
   logic        [IDX_W-1:0]          idx;
   logic        [PASS_W-1:0]         pass;
   logic        [IDX_W-1:0]          drain_idx;
   logic signed [DATA_WIDTH_SUM-1:0] entries [PSUM_DEPTH];
   logic signed [DATA_WIDTH_SUM-1:0] psum_q;
   logic                             psum_valid_q;
   logic                             prod_ready_q;
   logic                             busy_q;

   logic signed [DATA_WIDTH_SUM-1:0] prod_ext;
   logic                             prod_fire;
   logic                             psum_fire;

   assign prod_ext  = DATA_WIDTH_SUM'($signed(bus.prod_i));
   assign prod_fire = prod_ready_q && bus.prod_valid_i;
   assign psum_fire = psum_valid_q && bus.psum_ready_i;

   assign bus.prod_ready_o = prod_ready_q;
   assign bus.psum_valid_o = psum_valid_q;
   assign bus.psum_o       = psum_q;
   assign bus.psum_idx_o   = drain_idx;
   assign busy_o           = busy_q;

   // NOTE: the psum entries are reset along with the control state so that a reset
   // leaves no residue at all; clear_i deliberately skips them because pass 0 overwrites.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= ST_ACCUM;
         idx          <= '0;
         pass         <= '0;
         drain_idx    <= '0;
         psum_q       <= '0;
         psum_valid_q <= 1'b0;
         prod_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         for (int i = 0; i < PSUM_DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (clear_i) begin
         state        <= ST_ACCUM;
         idx          <= '0;
         pass         <= '0;
         drain_idx    <= '0;
         psum_valid_q <= 1'b0;
         prod_ready_q <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         case (state)
            ST_ACCUM: begin
               if (prod_fire) begin
                  entries[idx] <= (pass == '0) ? prod_ext : entries[idx] + prod_ext;
                  busy_q       <= 1'b1;
                  if (idx == LAST_IDX) begin
                     idx <= '0;
                     if (pass == LAST_PASS) begin
                        // Entry 0 is already final here, so the drain starts without a bubble.
                        pass         <= '0;
                        drain_idx    <= '0;
                        psum_q       <= entries[0];
                        psum_valid_q <= 1'b1;
                        prod_ready_q <= 1'b0;
                        state        <= ST_DRAIN;
                     end else begin
                        pass <= pass + PASS_W'(1);
                     end
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end

            ST_DRAIN: begin
               if (psum_fire) begin
                  if (drain_idx == LAST_IDX) begin
                     drain_idx    <= '0;
                     psum_valid_q <= 1'b0;
                     prod_ready_q <= 1'b1;
                     busy_q       <= 1'b0;
                     state        <= ST_ACCUM;
                  end else begin
                     drain_idx <= drain_idx + IDX_W'(1);
                     psum_q    <= entries[drain_idx + IDX_W'(1)];
                  end
               end
            end

            default: state <= ST_ACCUM;
         endcase
      end
   end
endmodule
